// File: rtl/ifmap_packet_tx_pkg.sv
// rtl/ifmap_packet_tx_pkg.sv - shared ifmap types, layer row sizes and row-length helper
`ifndef L1_IFMAP_SIZE
`define L1_IFMAP_SIZE 227
`endif
`ifndef L2_IFMAP_SIZE
`define L2_IFMAP_SIZE 31
`endif
`ifndef L3_IFMAP_SIZE
`define L3_IFMAP_SIZE 15
`endif

package ifmap_packet_tx_pkg;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } OP_MODE;

    typedef struct packed {
        logic            valid;
        logic [4:0]      packet_idx;
        logic [3:0][7:0] data;
    } PE_IN_PACKET;

    // One queued packet: everything but the valid bit
    typedef struct packed {
        logic [4:0]      packet_idx;
        logic [3:0][7:0] data;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_t;

    // Byte counter width; wide enough for the padded length of the longest row
    localparam int CNT_W = 10;

    // Row length in bytes for a layer mode
    function automatic logic [CNT_W-1:0] size_of_mode(input OP_MODE m);
        case (m)
            MODE1, MODE2: return CNT_W'(`L1_IFMAP_SIZE);
            MODE3:        return CNT_W'(`L2_IFMAP_SIZE);
            default:      return CNT_W'(`L3_IFMAP_SIZE);
        endcase
    endfunction

endpackage

// File: rtl/ifmap_packet_tx_if.sv
// rtl/ifmap_packet_tx_if.sv - control, ifmap buffer and PE packet signals of the transmitter
interface ifmap_packet_tx_if
    import ifmap_packet_tx_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ROW_IDX_W = 3
);
    OP_MODE                mode_in;
    logic                  start;
    logic [ADDR_W-1:0]     base_addr;
    logic [ROW_IDX_W-1:0]  row_idx;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [7:0]            rd_data;
    logic                  full;
    PE_IN_PACKET           ifmap_packet;
    logic                  busy;
    logic                  done;

    modport master (
        input  mode_in, start, base_addr, row_idx, rd_data, full,
        output rd_en, rd_addr, ifmap_packet, busy, done
    );

    modport slave (
        output mode_in, start, base_addr, row_idx, rd_data, full,
        input  rd_en, rd_addr, ifmap_packet, busy, done
    );
endinterface

// File: rtl/ifmap_packet_tx_fifo.sv
// rtl/ifmap_packet_tx_fifo.sv - 2-entry first-word-fall-through packet FIFO
module ifmap_pkt_fifo
    import ifmap_packet_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t wr_entry,
    input  logic        pop,
    output fifo_entry_t rd_entry,
    output logic        empty,
    output logic        full
);
    fifo_entry_t mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign rd_entry = mem[rd_ptr];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/ifmap_packet_tx.sv
// rtl/ifmap_packet_tx.sv - reads one ifmap row byte-wise and sends 4-byte packets to the PE
module ifmap_packet_tx
    import ifmap_packet_tx_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int ROW_IDX_W = 3
)(
    input  logic                clk,
    input  logic                rst,
    ifmap_packet_tx_if.master   bus
);
    tx_state_t              state_q;
    tx_state_t              state_d;
    OP_MODE                 mode_q;
    logic [ADDR_W-1:0]      base_q;
    logic [ROW_IDX_W-1:0]   row_q;
    logic [CNT_W-1:0]       b_q;
    logic                   in_grp_q;
    logic                   cap_vld_q;
    logic                   cap_pad_q;
    logic [1:0]             cap_lane_q;
    logic [2:0][7:0]        asm_q;
    logic                   done_q;

    logic [CNT_W-1:0]       row_len;
    logic [CNT_W-3:0]       grp_cnt;
    logic [CNT_W-1:0]       total_len;
    logic                   fetch_end;
    logic                   slot_ok;
    logic                   advance;
    logic                   issue_read;
    logic [7:0]             lane_byte;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   fifo_full;
    fifo_entry_t            wr_entry;
    fifo_entry_t            head;

    // Row length rounded up to whole packets
    assign row_len   = size_of_mode(mode_q);
    assign grp_cnt   = row_len[CNT_W-1:2] + {{(CNT_W-3){1'b0}}, |row_len[1:0]};
    assign total_len = {grp_cnt, 2'b00};
    assign fetch_end = (b_q == total_len);

    // A new group may only start if a FIFO slot is still free counting the
    // group still waiting to be pushed; pops are ignored, which is safe.
    assign slot_ok    = !fifo_full && !(in_grp_q && !fifo_empty);
    assign advance    = (state_q == ST_FETCH) && !fetch_end && ((b_q[1:0] != 2'd0) || slot_ok);
    assign issue_read = advance && (b_q < row_len);

    assign lane_byte = cap_pad_q ? 8'h00 : bus.rd_data;
    assign push      = cap_vld_q && (cap_lane_q == 2'd3);
    assign pop       = !fifo_empty && !bus.full;
    assign wr_entry  = '{packet_idx: 5'(row_q), data: {lane_byte, asm_q[2], asm_q[1], asm_q[0]}};

    ifmap_pkt_fifo u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: fetch until the last group is queued, then drain the FIFO
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_FETCH;
            ST_FETCH: if (fetch_end && push) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && !fifo_full) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: buffer read port, busy flag and the packet at the FIFO head
    always_comb begin
        bus.rd_en        = issue_read;
        bus.rd_addr      = issue_read ? (base_q + ADDR_W'(b_q)) : '0;
        bus.busy         = (state_q != ST_IDLE);
        bus.done         = done_q;
        bus.ifmap_packet = '0;
        if (pop) begin
            bus.ifmap_packet.valid      = 1'b1;
            bus.ifmap_packet.packet_idx = head.packet_idx;
            bus.ifmap_packet.data       = head.data;
        end
    end

    // Row parameters latched on an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE1;
            base_q <= '0;
            row_q  <= '0;
        end else if (state_q == ST_IDLE && bus.start) begin
            mode_q <= bus.mode_in;
            base_q <= bus.base_addr;
            row_q  <= bus.row_idx;
        end
    end

    // Byte counter, group reservation flag and the one-cycle read return pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q        <= '0;
            in_grp_q   <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_pad_q  <= 1'b0;
            cap_lane_q <= 2'd0;
        end else begin
            if (state_q == ST_IDLE && bus.start) b_q <= '0;
            else if (advance)                    b_q <= b_q + 1'b1;
            if (advance && b_q[1:0] == 2'd0) in_grp_q <= 1'b1;
            else if (push)                   in_grp_q <= 1'b0;
            cap_vld_q  <= advance;
            cap_pad_q  <= !issue_read;
            cap_lane_q <= b_q[1:0];
        end
    end

    // Lanes 0..2 collect returned bytes; lane 3 goes straight into the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q <= '0;
        end else if (cap_vld_q) begin
            case (cap_lane_q)
                2'd0:    asm_q[0] <= lane_byte;
                2'd1:    asm_q[1] <= lane_byte;
                2'd2:    asm_q[2] <= lane_byte;
                default: ;
            endcase
        end
    end

    // done pulses in the cycle the FSM returns to idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
    end
endmodule

// File: tb/tb_ifmap_packet_tx.sv
// tb/tb_ifmap_packet_tx.sv - self-checking bench for ifmap_packet_tx
module tb_ifmap_packet_tx;
    import ifmap_packet_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifmap_packet_tx_if #(.ADDR_W(16), .ROW_IDX_W(3)) bus ();
    ifmap_packet_tx #(.ADDR_W(16), .ROW_IDX_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        OP_MODE      mode;
        logic [15:0] base;
        logic [2:0]  ridx;
        int          fmode;
        bit          restart;
        int          mem_pat;
        int          exp_pkts;
    } vec_t;

    vec_t        vecs [7];
    logic [7:0]  mem [65536];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;

    PE_IN_PACKET got_q [$];
    int  rd_cnt, done_cnt, done_cyc, last_acc_cyc, first_addr, busy_glitch, full_leak;
    bit  first_seen;
    logic busy_prev = 1'b0;
    int  fmode = 0;
    int  hold_cnt = 0;
    bit  hold_done = 1'b0;
    int  hold_size = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int ref_len(input OP_MODE m);
        case (m)
            MODE1, MODE2: return `L1_IFMAP_SIZE;
            MODE3:        return `L2_IFMAP_SIZE;
            default:      return `L3_IFMAP_SIZE;
        endcase
    endfunction

    task automatic fill_mem(input int pat);
        for (int i = 0; i < 65536; i++) mem[i] = (pat == 0) ? 8'(i) : 8'($urandom);
    endtask

    always @(posedge clk) cyc++;

    // Buffer model: data one cycle after rd_en
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    // Back-pressure generator, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        if (fmode == 1) begin
            bus.full = (bus.full === 1'b1) ? 1'b0 : 1'b1;
        end else if (fmode == 2) begin
            bus.full = ($urandom_range(0, 2) == 0);
        end else if (fmode == 3) begin
            if (!hold_done && got_q.size() >= 6) begin
                hold_done = 1'b1;
                hold_cnt  = 10;
            end
            if (hold_cnt > 0) begin
                bus.full = 1'b1;
                hold_cnt--;
            end else begin
                bus.full = 1'b0;
                if (hold_done && hold_size < 0) hold_size = got_q.size();
            end
        end else begin
            bus.full = 1'b0;
        end
    end

    // Observation away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ifmap_packet.valid) begin
                got_q.push_back(bus.ifmap_packet);
                last_acc_cyc = cyc;
                if (bus.full) full_leak++;
            end
            if (bus.rd_en) begin
                if (!first_seen) first_addr = int'(bus.rd_addr);
                first_seen = 1'b1;
                rd_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy_prev && !bus.busy && !bus.done) busy_glitch++;
            busy_prev = bus.busy;
        end
    end

    task automatic clear_obs(input int fm);
        got_q.delete();
        rd_cnt = 0; done_cnt = 0; done_cyc = -1; last_acc_cyc = -100;
        first_addr = -1; first_seen = 1'b0; busy_glitch = 0; full_leak = 0;
        busy_prev = 1'b0; fmode = fm; hold_cnt = 0; hold_done = 1'b0; hold_size = -1;
    endtask

    task automatic compare_row(input OP_MODE m, input logic [15:0] base, input logic [2:0] ridx,
                               input int exp_pkts, input int fm, input string tag);
        int n;
        int p;
        logic [37:0] exp;
        n = ref_len(m);
        p = (n + 3) / 4;
        check({tag, " pkt_count"}, 64'(got_q.size()), 64'(exp_pkts));
        for (int i = 0; i < p && i < got_q.size(); i++) begin
            exp = {1'b1, 2'b00, ridx, 32'h0};
            for (int k = 0; k < 4; k++)
                if (4 * i + k < n) exp[8*k +: 8] = mem[16'(int'(base) + 4 * i + k)];
            check($sformatf("%s pkt%0d", tag, i), 64'(got_q[i]), 64'(exp));
        end
        check({tag, " rd_count"}, 64'(rd_cnt), 64'(n));
        check({tag, " first_rd_addr"}, 64'(first_addr), 64'(base));
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " done_latency"}, 64'(done_cyc), 64'(last_acc_cyc + 1));
        check({tag, " busy_gap"}, 64'(busy_glitch), 64'd0);
        check({tag, " valid_while_full"}, 64'(full_leak), 64'd0);
        if (fm == 3) check({tag, " held_at_6"}, 64'(hold_size), 64'd6);
    endtask

    task automatic run_row(input OP_MODE m, input logic [15:0] base, input logic [2:0] ridx,
                           input int fm, input bit restart, input int exp_pkts, input string tag);
        int t;
        clear_obs(fm);
        @(posedge clk); #1;
        check({tag, " busy_idle"}, 64'(bus.busy), 64'd0);
        bus.mode_in = m; bus.base_addr = base; bus.row_idx = ridx; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, " busy_rise"}, 64'(bus.busy), 64'd1);
        if (restart) begin
            repeat (30) @(posedge clk);
            #1;
            bus.mode_in = MODE4; bus.row_idx = ridx ^ 3'h5; bus.base_addr = base + 16'd7; bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        check({tag, " done_seen"}, 64'(done_cnt > 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        compare_row(m, base, ridx, exp_pkts, fm, tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        OP_MODE rm;
        vecs[0] = '{MODE1, 16'd0,    3'd3, 0, 1'b0, 0, 57};
        vecs[1] = '{MODE1, 16'd0,    3'd3, 3, 1'b0, 0, 57};
        vecs[2] = '{MODE1, 16'd0,    3'd3, 1, 1'b0, 0, 57};
        vecs[3] = '{MODE1, 16'd0,    3'd3, 0, 1'b1, 0, 57};
        vecs[4] = '{MODE3, 16'd100,  3'd5, 0, 1'b0, 1, 8};
        vecs[5] = '{MODE2, 16'd300,  3'd1, 2, 1'b0, 1, 57};
        vecs[6] = '{MODE4, 16'd4000, 3'd7, 1, 1'b0, 1, 4};

        bus.start = 1'b0; bus.mode_in = MODE1; bus.base_addr = '0; bus.row_idx = '0;
        clear_obs(0);
        repeat (3) @(posedge clk);
        #2;
        check("reset rd_en", 64'(bus.rd_en), 64'd0);
        check("reset rd_addr", 64'(bus.rd_addr), 64'd0);
        check("reset ifmap_packet", 64'(bus.ifmap_packet), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            fill_mem(vecs[v].mem_pat);
            run_row(vecs[v].mode, vecs[v].base, vecs[v].ridx, vecs[v].fmode, vecs[v].restart,
                    vecs[v].exp_pkts, $sformatf("vec%0d", v));
            if (v == 0 && got_q.size() == 57) begin
                check("vec0 first_data", 64'(got_q[0].data), 64'h03020100);
                check("vec0 last_data", 64'(got_q[56].data), 64'h00e2e1e0);
                check("vec0 idx", 64'(got_q[30].packet_idx), 64'h03);
            end
        end

        for (int r = 0; r < 4; r++) begin
            fill_mem(1);
            rm = OP_MODE'($urandom_range(0, 3));
            run_row(rm, 16'($urandom_range(0, 60000)), 3'($urandom), 2, 1'b0,
                    (ref_len(rm) + 3) / 4, $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a row, then a fresh row from element 0
        fill_mem(0);
        clear_obs(0);
        @(posedge clk); #1;
        bus.mode_in = MODE1; bus.base_addr = 16'd0; bus.row_idx = 3'd3; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        t = 0;
        while (got_q.size() < 21 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("mid_reset reached_pkt20", 64'(got_q.size() >= 21), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_reset rd_en", 64'(bus.rd_en), 64'd0);
        check("mid_reset rd_addr", 64'(bus.rd_addr), 64'd0);
        check("mid_reset ifmap_packet", 64'(bus.ifmap_packet), 64'd0);
        check("mid_reset busy", 64'(bus.busy), 64'd0);
        check("mid_reset done", 64'(bus.done), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        run_row(MODE1, 16'd0, 3'd3, 0, 1'b0, 57, "after_reset");
        if (got_q.size() > 0)
            check("after_reset first_data", 64'(got_q[0].data), 64'h03020100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ifmap_packet_tx.md
Name: ifmap_packet_tx

Overview:
Transmitter that feeds the PE ifmap input. On a start pulse it reads one ifmap row byte-by-byte from the global ifmap buffer and packs 4 bytes per PE_IN_PACKET. It honours the PE `full` back-pressure and zero-pads the final packet. It sits between the ifmap global buffer and the PE broadcast bus, and replaces the bench-driven ifmap stream.

Parameters:
ADDR_W, 16, ifmap buffer byte-address width
ROW_IDX_W, 3, width of the packet_idx[2:0] row tag

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
mode_in  in  OP_MODE  layer mode; sampled on accepted start
start  in  1  one-cycle pulse; begins one row transfer
base_addr  in  ADDR_W  byte address of ifmap element 0
row_idx  in  ROW_IDX_W  copied to packet_idx[2:0]; sampled on start
rd_en  out  1  buffer read enable
rd_addr  out  ADDR_W  buffer byte address
rd_data  in  8  read data, valid exactly 1 cycle after rd_en
full  in  1  PE ifmap scratch pad full
ifmap_packet  out  PE_IN_PACKET  {valid, packet_idx[4:0], data[3:0][7:0]}
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the last packet is sent

Behaviour:
- Reset values: rd_en=0, rd_addr=0, ifmap_packet='0, busy=0, done=0. FSM goes to IDLE. FIFO is emptied. All counters are 0. Reset mid-transfer aborts immediately with no partial packet; the next start restarts from element 0.
- Row length N:
  - MODE1/MODE2: `L1_IFMAP_SIZE (227).
  - MODE3: `L2_IFMAP_SIZE.
  - MODE4: `L3_IFMAP_SIZE.
- Packet count P = ceil(N/4); for N=227, P=57.
- FSM IDLE -> FETCH on start. Start is ignored while busy.
  - busy rises the cycle after start and stays high until done.
- FETCH: a byte counter b runs 0..4P-1 and advances one per cycle when the FIFO has a free slot (see next bullet).
  - b<N: rd_en=1, rd_addr=base_addr+b. The returned byte lands in lane b%4 of the assembly register one cycle later.
  - b>=N: no read; lane b%4 is forced to 8'h00.
  - Lane 3 completion pushes the assembled packet into the FIFO.
- Stall rule: FETCH must not start a new 4-byte group unless the FIFO will have a free slot when that group completes. Never drop or overwrite data.
- FSM FETCH -> DRAIN after the last group is pushed. DRAIN -> IDLE when the FIFO is empty and the last packet has been accepted. done pulses in that IDLE-entry cycle.
- Send side:
  - ifmap_packet.valid = fifo_not_empty && !full. This is combinational on full, so a PE that becomes full at an edge blocks the same-cycle issue.
  - A packet counts as accepted at any rising edge where valid=1. FIFO pops on acceptance.
  - valid may stay high on consecutive cycles (back-to-back) while full=0.
  - While full=1, valid=0 and the FIFO head is held unchanged.
  - Data and packet_idx come from the FIFO head. packet_idx[2:0]=row_idx and packet_idx[4:3]=0.
- Ordering: packets leave in ascending element order. data[k] holds element 4*p+k.
- Simultaneous FIFO push and pop are legal in the same cycle.
- Throughput is at most 1 packet per 4 cycles, limited by the byte-wide buffer.

Decomposition:
- Package: OP_MODE, PE_IN_PACKET, the L1/L2/L3 `*_IFMAP_SIZE macros, and a size_of_mode function returning N. All already shared; the function is new.
- Sub-module: ifmap_pkt_fifo, a 2-entry first-word-fall-through FIFO of {packet_idx, data}, with push, pop, empty and full signals.

Test Plan:
1. MODE1, bytes mem[i]=i[7:0], full=0, base_addr=0, row_idx=3 -> 57 packets.
   - Packet 0 data={03,02,01,00}; packet 56 data={00,E2,E1,E0}.
   - packet_idx=5'b00011 on every packet; done one cycle after packet 56; 227 rd_en pulses in total.
2. Same as test 1, but full forced high for 10 cycles after packet 5 -> valid=0 for those 10 cycles. Packet 6 is sent first after release; there are no lost or duplicated packets (57 total).
3. full toggling every cycle -> every accepted packet matches the golden 4-byte group and order is preserved.
4. start pulsed again while busy -> ignored; only 57 packets total; busy stays high continuously.
5. rst asserted after packet 20 -> all outputs return to 0 asynchronously. A new start then produces a full 57-packet stream beginning with elements 0..3.
6. MODE3 with base_addr=100 -> ceil(`L2_IFMAP_SIZE/4) packets; first rd_addr=100; pad lanes are 0 when `L2_IFMAP_SIZE%4 != 0.
